// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them to
// consecutive instruction-memory addresses until a halt, an overflow or a bad immediate.
module instruction_encoder #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [5:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs,
   input  logic [4:0]            in_rt,
   input  logic [4:0]            in_shamt,
   input  logic [31:0]           in_imm,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [1:0]            dbg_state
);

   // Handshake: a bundle transfers on a rising edge where in_valid and in_ready
   // are both high; in_ready is a pure decode of the current state and count.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE_PTR = BASE_ADDR[ADDR_WIDTH-1:0];
   localparam logic [ADDR_WIDTH:0]   MAX_CNT  = MAX_WORDS[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   r_word_count;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [1:0]            r_err_code;

   logic [31:0]           w_word;
   logic                  w_imm_chk;
   logic                  w_imm_ok;
   logic                  w_xfer;
   logic                  w_overflow;
   logic                  w_imm_err;
   logic                  w_write;
   logic                  w_halt;
   logic                  w_start;

   always_comb begin
      w_word    = 32'h0000_0000;
      w_imm_chk = 1'b0;
      w_imm_ok  = (in_imm[31:15] == '0) || (in_imm[31:15] == '1);
      if (in_opcode == 6'd0) begin
         w_word = 32'h0000_0000;
      end else if (in_opcode < 6'd16) begin
         w_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, 6'b000000};
      end else if (in_opcode < 6'd24) begin
         w_word    = {in_opcode, in_rd, in_rs, in_imm[15:0]};
         w_imm_chk = 1'b1;
      end else if (in_opcode < 6'd28) begin
         w_word    = {in_opcode, in_rd, in_rt, in_imm[15:0]};
         w_imm_chk = 1'b1;
      end else begin
         w_word    = {in_opcode, in_rs, in_rt, in_imm[15:0]};
         w_imm_chk = 1'b1;
      end
   end

   // Ready stays high at the capacity limit so that the overflowing bundle is seen and reported.
   assign in_ready   = (r_state == ST_LOAD) && (r_word_count <= MAX_CNT);
   assign w_xfer     = in_valid && in_ready;
   assign w_overflow = w_xfer && (r_word_count == MAX_CNT);
   assign w_imm_err  = w_xfer && !w_overflow && w_imm_chk && !w_imm_ok;
   assign w_write    = w_xfer && !w_overflow && !w_imm_err;
   assign w_halt     = w_write && (in_opcode == 6'd0);
   assign w_start    = start && (r_state != ST_LOAD);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_overflow || w_imm_err) w_state_next = ST_ERROR;
            else if (w_halt)             w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr        <= '0;
         r_word_count <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_err_code   <= 2'b00;
      end else begin
         r_we   <= w_write;
         r_busy <= (w_state_next == ST_LOAD);
         if (w_start) begin
            r_ptr        <= BASE_PTR;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'b00;
         end
         if (w_write) begin
            r_addr       <= r_ptr;
            r_wdata      <= w_word;
            r_ptr        <= r_ptr + PTR_ONE;
            r_word_count <= r_word_count + CNT_ONE;
         end
         if (w_halt) r_done <= 1'b1;
         if (w_overflow) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b10;
         end
         if (w_imm_err) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b01;
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign err_code   = r_err_code;
   assign word_count = r_word_count;
   assign dbg_state  = r_state;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential instruction encoder and program loader, the write-side counterpart of the CPU's instruction decoder. Accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit instruction words using the CPU's opcode-class formats, and writes them to consecutive instruction-memory addresses. Sits between the testbench or boot source and the instruction memory. Loading stops on a halt (opcode 0), on overflow, or on an encoding error.

## Interface
- `ADDR_WIDTH`, 10: instruction-memory word-address width.
- `BASE_ADDR`, 0: first address written after `start`.
- `MAX_WORDS`, 1024: capacity in words, including the halt word.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: one-cycle pulse that begins a load session.
- `in_valid` input, 1 bit: field bundle valid.
- `in_ready` output, 1 bit: encoder can accept the bundle.
- `in_opcode` input, 6 bits: opcode, placed in `[31:26]`.
- `in_rd` input, 5 bits: destination register (R/I class) or base register (memory class).
- `in_rs` input, 5 bits: first source register.
- `in_rt` input, 5 bits: second source register (R/branch class) or data register (memory class).
- `in_shamt` input, 5 bits: shift amount (R class only).
- `in_imm` input, 32 bits: signed immediate; must fit in 16-bit two's complement.
- `imem_we` output, 1 bit: instruction-memory write strobe.
- `imem_addr` output, ADDR_WIDTH bits: write address.
- `imem_wdata` output, 32 bits: encoded instruction word.
- `busy` output, 1 bit: state is LOAD.
- `done` output, 1 bit: halt word written. Held until the next `start` or reset.
- `error` output, 1 bit: session aborted. Held until the next `start` or reset.
- `err_code` output, 2 bits: 01 = immediate out of range, 10 = capacity overflow, 00 = none.
- `word_count` output, ADDR_WIDTH+1 bits: number of words written in this session.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: accepting and writing words.
  - DONE: halt word written.
  - ERROR: session aborted.
- `start` moves IDLE, DONE or ERROR to LOAD. On that edge:
  - `word_count` = 0;
  - address pointer = `BASE_ADDR`;
  - `done`, `error` and `err_code` are cleared.
- `start` is ignored while in LOAD.
- `in_ready` = 1 only in LOAD, and only when no pending write has reached capacity.
- A transfer is `in_valid & in_ready` sampled on a rising edge.
- Encoding is selected by opcode class:
  - Opcode 0 (halt): the word is 32'h0000_0000. All other fields are ignored.
  - Opcode 1–15 (R class): `{op, rd, rs, rt, shamt, 6'b0}`.
  - Opcode 16–23 (I class): `{op, rd, rs, imm[15:0]}`.
  - Opcode 24–27 (memory class): `{op, rd, rt, imm[15:0]}`.
  - Opcode 28–63 (branch class): `{op, rs, rt, imm[15:0]}`.
- Immediate range check:
  - Applies to the I, memory and branch classes.
  - Passes only if `in_imm[31:15]` is all 0s or all 1s.
  - Never checked for R class or halt.
- A failed immediate check:
  - performs no write;
  - sets `err_code` = 01 and moves to ERROR.
- Capacity overflow: a transfer when `word_count == MAX_WORDS` performs no write, sets `err_code` = 10 and moves to ERROR.
- Halt gets no special capacity treatment: if it arrives at `word_count == MAX_WORDS`, that is an overflow.
- A successful transfer writes one word and increments both the address pointer and `word_count`.
- After the halt word is written, the state moves to DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap is legal and is not an error; only `MAX_WORDS` bounds a session.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0;
  - `busy` = 0, `done` = 0, `error` = 0, `err_code` = 00, `word_count` = 0.
- Reset mid-session aborts immediately. No further writes occur.
- `start` is sampled at edge N. LOAD, `busy` = 1 and `in_ready` = 1 are visible after edge N.
- Write latency:
  - a transfer accepted at edge N drives `imem_we`, `imem_addr` and `imem_wdata` as registered outputs for exactly the cycle after edge N;
  - memory commits at edge N+1.
- `word_count` updates at edge N, and so reflects the accepted word one cycle before the memory commit.
- Throughput is one word per cycle under back-to-back `in_valid`.
- After a halt is accepted at edge N:
  - `in_ready` = 0 and `busy` = 0 after edge N;
  - the halt write is still issued in cycle N+1;
  - `done` = 1 after edge N.
- After an error at edge N:
  - `error` and `err_code` are valid after edge N;
  - `imem_we` = 0 in cycle N+1.
- `start` and `in_valid` together in DONE or ERROR: only `start` is taken. Data is not accepted until the following cycle.
- All outputs are registered except `in_ready`, which is decoded from the current state and `word_count`.

## Test plan
- Reset, `start`, then send R-type {op=3, rd=5, rs=1, rt=2, shamt=4}, then halt -> writes 0x0CA1_1100 at addr 0 and 0x0000_0000 at addr 1. `done` = 1, `word_count` = 2.
- I-type {op=18, rd=7, rs=3, imm=-2} -> `imem_wdata` = 0x48E3_FFFE. Then imm = 32768 -> no write, `error` = 1, `err_code` = 01.
- Memory {op=25, rd=4, rt=9, imm=0x10} and branch {op=30, rs=1, rt=2, imm=-8} back-to-back -> 0x6489_0010 and 0x7822_FFF8 written in consecutive cycles.
- With `MAX_WORDS` = 4, send 4 words and then a 5th (a halt) -> 4 writes, `err_code` = 10, no 5th write.
- `rst_n` low for one cycle mid-stream -> `imem_we` = 0 from the next cycle, state IDLE. A later `start` writes again from `BASE_ADDR`.
- `start` while in LOAD is ignored. `start` in DONE clears `done` and restarts from `BASE_ADDR` with `word_count` = 0.
